// File: rtl/result_drain_reader_if.sv
// Bundles the drain command, the results-SRAM read port and the output row stream.
// master = the drain reader itself, slave = its environment (controller, SRAM, consumer).
interface result_drain_reader_if #(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int MATRIX_SIZE    = 64,
    parameter int LEN_BW         = 7
);
    localparam int ROW_W = PARTIAL_SUM_BW * MATRIX_SIZE;

    logic                   drain_start;
    logic [ADDRESSSIZE-1:0] drain_base;
    logic [LEN_BW-1:0]      drain_len;
    logic                   sram_rd_en;
    logic [ADDRESSSIZE-1:0] sram_addr;
    logic [ROW_W-1:0]       sram_rdata;
    logic                   m_valid;
    logic                   m_ready;
    logic [ROW_W-1:0]       m_data;
    logic [LEN_BW-1:0]      m_row;
    logic                   m_last;
    logic                   busy;
    logic                   done;

    modport master (
        input  drain_start, drain_base, drain_len, sram_rdata, m_ready,
        output sram_rd_en, sram_addr, m_valid, m_data, m_row, m_last, busy, done
    );

    modport slave (
        output drain_start, drain_base, drain_len, sram_rdata, m_ready,
        input  sram_rd_en, sram_addr, m_valid, m_data, m_row, m_last, busy, done
    );
endinterface

// File: rtl/result_drain_reader.sv
// Walks a programmed results-SRAM address range and streams each row out on valid/ready.
// Latency: drain_start to first m_valid is 3 cycles; 1 row/cycle sustained with m_ready high.
// Backpressure: 2-entry skid FIFO plus read credits; rows are held stable while m_ready is low.
module result_drain_reader #(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int MATRIX_SIZE    = 64,
    parameter int LEN_BW         = 7
) (
    input  logic                 clk,
    input  logic                 rstn,
    result_drain_reader_if.master bus
);
    localparam int ROW_W = PARTIAL_SUM_BW * MATRIX_SIZE;

    typedef struct packed {
        logic [ROW_W-1:0]  dat;
        logic [LEN_BW-1:0] row;
        logic              last;
    } beat_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDRESSSIZE-1:0] base_q, base_d;
    logic [ADDRESSSIZE-1:0] addr_q;
    logic [LEN_BW-1:0]      len_q, len_d;
    logic [LEN_BW-1:0]      issued_q, issued_d;
    logic [LEN_BW-1:0]      infl_row_q;
    logic                   inflight_q;
    logic                   rd_en;

    beat_t                  fifo_mem_q [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             cnt_q;
    logic                   fifo_vld;
    logic                   pop;
    logic [2:0]             credit;
    beat_t                  push_beat, head;

    assign fifo_vld = (cnt_q != 2'd0);
    assign pop      = fifo_vld && bus.m_ready;
    assign head     = fifo_mem_q[rd_ptr_q];

    // Credits count the slot freed by this cycle's pop so a full-rate drain never bubbles.
    assign credit = {1'b0, cnt_q} - {2'b0, pop} + {2'b0, inflight_q};

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q;
        rd_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.drain_start) begin
                    base_d   = bus.drain_base;
                    len_d    = bus.drain_len;
                    issued_d = '0;
                    state_d  = (bus.drain_len != '0) ? S_READ : S_FIN;
                end
            end
            S_READ: begin
                if (credit < 3'd2) begin
                    rd_en    = 1'b1;
                    issued_d = issued_q + LEN_BW'(1);
                    if (issued_q == len_q - LEN_BW'(1)) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (pop && head.last) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.sram_rd_en = rd_en;
    assign bus.sram_addr  = rd_en ? (base_q + ADDRESSSIZE'(issued_q)) : addr_q;

    assign push_beat.dat  = bus.sram_rdata;
    assign push_beat.row  = infl_row_q;
    assign push_beat.last = (infl_row_q == len_q - LEN_BW'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            infl_row_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            addr_q     <= bus.sram_addr;
            inflight_q <= rd_en;
            if (rd_en) begin
                infl_row_q <= issued_q;
            end
            if (inflight_q) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    // Row storage needs no reset: cnt_q gates every use of it.
    always_ff @(posedge clk) begin
        if (inflight_q) begin
            fifo_mem_q[wr_ptr_q] <= push_beat;
        end
    end

    assert property (@(posedge clk) disable iff (!rstn) !(inflight_q && cnt_q == 2'd2));

    assign bus.m_valid = fifo_vld;
    assign bus.m_data  = fifo_vld ? head.dat : '0;
    assign bus.m_row   = fifo_vld ? head.row : '0;
    assign bus.m_last  = fifo_vld && head.last;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_FIN);
endmodule

// File: tb/tb_result_drain_reader.sv
// Randomized bench: behavioural SRAM plus an expected-row queue built from base/len arithmetic.
module tb_result_drain_reader;
    localparam int AW   = 10;
    localparam int PSBW = 24;
    localparam int MS   = 64;
    localparam int LBW  = 7;
    localparam int RW   = PSBW * MS;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    result_drain_reader_if #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(PSBW), .MATRIX_SIZE(MS), .LEN_BW(LBW)) bus ();

    result_drain_reader #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(PSBW), .MATRIX_SIZE(MS), .LEN_BW(LBW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [RW-1:0] mem [1024];
    always @(posedge clk) begin
        if (bus.sram_rd_en) bus.sram_rdata <= mem[bus.sram_addr];
    end

    typedef struct {
        logic [RW-1:0] dat;
        int            row;
        bit            last;
    } exp_t;

    exp_t          beat_q [$];
    logic [AW-1:0] addr_q [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ready_mode, rcnt;
    int outstanding, max_out, n_busy, n_done, n_beats, n_rd;
    int first_rd, last_rd, first_vld, last_hs, done_cyc;
    bit          prev_stall;
    logic [63:0] prev_fold;
    logic [LBW-1:0] prev_row;
    logic        prev_last;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] fold(input logic [RW-1:0] d);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < RW / 64; i++) f = {f[62:0], f[63]} ^ d[i*64 +: 64];
        return f;
    endfunction

    task automatic clear_drain();
        outstanding = 0; max_out = 0; n_busy = 0; n_done = 0; n_beats = 0; n_rd = 0;
        first_rd = -1; last_rd = -1; first_vld = -1; last_hs = -1; done_cyc = -1;
        prev_stall = 1'b0; rcnt = 0;
    endtask

    // Observes what the next rising edge will act on (inputs already driven for it).
    task automatic observe();
        exp_t        e;
        logic [63:0] f;
        if (!rstn) return;
        f = fold(bus.m_data);
        if (bus.m_valid) begin
            if (prev_stall) begin
                check_eq("hold_data", f, prev_fold);
                check_eq("hold_row", 64'(bus.m_row), 64'(prev_row));
                check_eq("hold_last", 64'(bus.m_last), 64'(prev_last));
            end
            if (first_vld < 0) first_vld = cyc;
            if (bus.m_ready) begin
                if (beat_q.size() == 0) begin
                    check_eq("extra_beat", 1, 0);
                end else begin
                    e = beat_q.pop_front();
                    check_eq("beat_data", f, fold(e.dat));
                    check_eq("beat_row", 64'(bus.m_row), 64'(e.row));
                    check_eq("beat_last", 64'(bus.m_last), 64'(e.last));
                end
                outstanding--;
                n_beats++;
                if (bus.m_last) last_hs = cyc;
            end
        end else begin
            if (prev_stall) check_eq("valid_held", 64'(bus.m_valid), 1);
            check_eq("idle_row", 64'(bus.m_row), 0);
            check_eq("idle_last", 64'(bus.m_last), 0);
        end
        if (bus.sram_rd_en) begin
            if (addr_q.size() == 0) check_eq("extra_read", 1, 0);
            else check_eq("rd_addr", 64'(bus.sram_addr), 64'(addr_q.pop_front()));
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_fold  = f;
        prev_row   = bus.m_row;
        prev_last  = bus.m_last;
        if (bus.busy) n_busy++;
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic tick(input bit start, input logic [AW-1:0] b, input logic [LBW-1:0] l);
        @(negedge clk);
        cyc++;
        bus.drain_start = start;
        bus.drain_base  = b;
        bus.drain_len   = l;
        case (ready_mode)
            1:       bus.m_ready = 1'($urandom_range(0, 1));
            2:       bus.m_ready = (rcnt < 10) ? (rcnt % 2 == 0) : (rcnt >= 20);
            default: bus.m_ready = 1'b1;
        endcase
        rcnt++;
        #1 observe();
    endtask

    task automatic expect_rows(input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            addr_q.push_back(a);
            beat_q.push_back('{dat: mem[a], row: i, last: (i == len - 1)});
        end
    endtask

    task automatic run_drain(input logic [AW-1:0] base, input int len, input int mode, input int repulse);
        int start_cyc;
        clear_drain();
        ready_mode = mode;
        expect_rows(base, len);
        start_cyc = cyc + 1;
        tick(1'b1, base, LBW'(len));
        for (int k = 0; k < 400 && n_done == 0; k++)
            tick(k == repulse, AW'($urandom), LBW'($urandom));
        check_eq("done_seen", 64'(n_done), 1);
        tick(1'b0, AW'($urandom), LBW'($urandom));
        tick(1'b0, AW'($urandom), LBW'($urandom));
        check_eq("done_pulses", 64'(n_done), 1);
        check_eq("rows_left", 64'(beat_q.size()), 0);
        check_eq("addrs_left", 64'(addr_q.size()), 0);
        check_eq("beat_count", 64'(n_beats), 64'(len));
        check_eq("read_count", 64'(n_rd), 64'(len));
        check_eq("max_outstanding_le2", 64'(max_out <= 2), 1);
        check_eq("busy_cycles", 64'(n_busy), 64'(done_cyc - start_cyc));
        if (len > 0) check_eq("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
        else check_eq("len0_done_cycle", 64'(done_cyc), 64'(start_cyc + 1));
        if (mode == 0 && len > 0) begin
            check_eq("first_valid_latency", 64'(first_vld - start_cyc), 3);
            check_eq("reads_back_to_back", 64'(last_rd - first_rd), 64'(len - 1));
        end
        addr_q.delete();
        beat_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.drain_start = 1'b0;
        bus.drain_base  = '0;
        bus.drain_len   = '0;
        bus.m_ready     = 1'b1;
        ready_mode      = 0;
        clear_drain();
        for (int i = 0; i < 1024; i++)
            for (int w = 0; w < RW / 32; w++) mem[i][w*32 +: 32] = $urandom;

        #22;
        check_eq("rst_busy", 64'(bus.busy), 0);
        check_eq("rst_done", 64'(bus.done), 0);
        check_eq("rst_valid", 64'(bus.m_valid), 0);
        check_eq("rst_rd_en", 64'(bus.sram_rd_en), 0);
        check_eq("rst_addr", 64'(bus.sram_addr), 0);
        check_eq("rst_row", 64'(bus.m_row), 0);
        check_eq("rst_data", fold(bus.m_data), 0);
        @(negedge clk);
        rstn = 1'b1;

        run_drain(10'd0, 4, 0, -1);
        run_drain(10'd1022, 4, 0, -1);
        run_drain(AW'($urandom), 8, 2, -1);
        run_drain(AW'($urandom), 0, 0, -1);
        run_drain(10'd100, 8, 0, 3);

        // Abort mid-drain with asynchronous reset after two delivered rows.
        clear_drain();
        ready_mode = 0;
        expect_rows(10'd200, 6);
        tick(1'b1, 10'd200, LBW'(6));
        for (int k = 0; k < 50 && n_beats < 2; k++) tick(1'b0, AW'($urandom), LBW'($urandom));
        check_eq("abort_two_beats", 64'(n_beats), 2);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("abort_valid", 64'(bus.m_valid), 0);
        check_eq("abort_busy", 64'(bus.busy), 0);
        check_eq("abort_done", 64'(bus.done), 0);
        check_eq("abort_rd_en", 64'(bus.sram_rd_en), 0);
        check_eq("abort_row", 64'(bus.m_row), 0);
        check_eq("abort_last", 64'(bus.m_last), 0);
        addr_q.delete();
        beat_q.delete();
        repeat (3) @(negedge clk);
        check_eq("abort_no_done", 64'(n_done), 0);
        rstn = 1'b1;
        run_drain(10'd0, 4, 0, -1);

        for (int t = 0; t < 6; t++)
            run_drain(AW'($urandom), $urandom_range(1, 64), 1, -1);
        run_drain(10'd1000, 64, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
